// File: rtl/vga_frame_buffer_if.sv
// Write port of the frame buffer. The drawing engine is the master and the buffer is the slave.
interface vga_frame_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [2:0] wr_color;

  modport master (output wr_valid, output wr_x, output wr_y, output wr_color, input wr_ready);
  modport slave  (input wr_valid, input wr_x, input wr_y, input wr_color, output wr_ready);
endinterface

// File: rtl/vga_frame_buffer.sv
// Down-scaled 3-bit RGB frame store feeding the VGA driver. It has a one-clock registered
// read path, a valid/ready write port and a clear-to-colour engine.
module vga_frame_buffer #(
  parameter int SCREEN_X    = 1280,
  parameter int SCREEN_Y    = 1024,
  parameter int SCALE_SHIFT = 3,
  parameter int ADDR_W      = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         posX,
  input  logic [10:0]         posY,
  output logic [2:0]          pixel_out,
  vga_frame_buffer_if.slave   wrPort,
  input  logic                clr_start,
  input  logic [2:0]          clr_color,
  output logic                busy,
  output logic                clr_done,
  output logic [7:0]          oob_count
);

  localparam int FB_W  = SCREEN_X >> SCALE_SHIFT;
  localparam int FB_H  = SCREEN_Y >> SCALE_SHIFT;
  localparam int DEPTH = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            stateNext;
  logic [2:0]        mem [0:DEPTH-1];
  logic              readyReg;
  logic [ADDR_W-1:0] clrAddr;
  logic [2:0]        clrColorReg;
  logic              clrDoneReg;
  logic [7:0]        oobReg;
  logic [2:0]        pixelReg;

  logic              wrFire;
  logic              wrInRange;
  logic [ADDR_W-1:0] wrAddr;
  logic              rdInRange;
  logic [ADDR_W-1:0] rdAddr;
  logic              clrLast;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [2:0]        memData;

  // The range check runs on the raw coordinates, before the multiply, so an out-of-range
  // coordinate can never alias onto a valid cell.
  assign wrFire    = wrPort.wr_valid && wrPort.wr_ready;
  assign wrInRange = (int'(wrPort.wr_x) < FB_W) && (int'(wrPort.wr_y) < FB_H);
  assign wrAddr    = ADDR_W'(wrPort.wr_y) * ADDR_W'(FB_W) + ADDR_W'(wrPort.wr_x);
  assign rdInRange = (int'(posX) < SCREEN_X) && (int'(posY) < SCREEN_Y);
  assign rdAddr    = ADDR_W'(posY >> SCALE_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(posX >> SCALE_SHIFT);
  assign clrLast   = (clrAddr == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (clr_start) stateNext = CLEAR;
      CLEAR:   if (clrLast)   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // The clear engine owns the single write port while it runs, so writes wait instead of colliding.
  always_comb begin
    wrPort.wr_ready = readyReg && (state == IDLE);
    busy            = (state == CLEAR);
    memWe           = 1'b0;
    memAddr         = '0;
    memData         = 3'b000;
    if (state == CLEAR) begin
      memWe   = 1'b1;
      memAddr = clrAddr;
      memData = clrColorReg;
    end else if (wrFire && wrInRange) begin
      memWe   = 1'b1;
      memAddr = wrAddr;
      memData = wrPort.wr_color;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readyReg    <= 1'b0;
      clrAddr     <= '0;
      clrColorReg <= 3'b000;
      clrDoneReg  <= 1'b0;
      oobReg      <= 8'd0;
      pixelReg    <= 3'b000;
    end else begin
      readyReg   <= 1'b1;
      clrDoneReg <= (state == CLEAR) && clrLast;
      if (state == IDLE && clr_start) begin
        clrAddr     <= '0;
        clrColorReg <= clr_color;
      end else if (state == CLEAR) begin
        clrAddr <= clrAddr + 1'b1;
      end
      if (wrFire && !wrInRange && oobReg != 8'hFF) begin
        oobReg <= oobReg + 8'd1;
      end
      pixelReg <= rdInRange ? mem[rdAddr] : 3'b000;
    end
  end

  // Contents are deliberately not reset. An aborted clear leaves a partial fill behind.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= memData;
    end
  end

  assign pixel_out = pixelReg;
  assign clr_done  = clrDoneReg;
  assign oob_count = oobReg;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Self-checking bench for vga_frame_buffer. It uses table vectors, clear and reset
// sequences, and random traffic checked against an array model of the frame.
module tb_vga_frame_buffer;
  localparam int FB_W  = 160;
  localparam int FB_H  = 128;
  localparam int CELLS = FB_W * FB_H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] posX = '0;
  logic [10:0] posY = '0;
  logic [2:0]  pixel_out;
  logic        clr_start = 1'b0;
  logic [2:0]  clr_color = 3'b000;
  logic        busy;
  logic        clr_done;
  logic [7:0]  oob_count;

  vga_frame_buffer_if wrBus();

  always #5 clk = ~clk;

  vga_frame_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .posX      (posX),
    .posY      (posY),
    .pixel_out (pixel_out),
    .wrPort    (wrBus),
    .clr_start (clr_start),
    .clr_color (clr_color),
    .busy      (busy),
    .clr_done  (clr_done),
    .oob_count (oob_count)
  );

  int         checks = 0;
  int         errors = 0;
  logic [2:0] model [CELLS];
  int         oobModel = 0;

  typedef struct {
    int         px;
    int         py;
    logic [2:0] exp;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] expPix(input int px, input int py);
    if (px >= 1280 || py >= 1024) return 3'b000;
    return model[(py / 8) * FB_W + px / 8];
  endfunction

  // Each task starts just after a falling edge and also returns just after one.
  task automatic readCheck(input int px, input int py, input string name);
    posX = 11'(px);
    posY = 11'(py);
    @(posedge clk);
    @(negedge clk);
    check(name, int'(pixel_out), int'(expPix(px, py)));
  endtask

  task automatic doWrite(input int x, input int y, input logic [2:0] c);
    wrBus.wr_valid = 1'b1;
    wrBus.wr_x     = 8'(x);
    wrBus.wr_y     = 7'(y);
    wrBus.wr_color = c;
    @(posedge clk);
    @(negedge clk);
    wrBus.wr_valid = 1'b0;
    if (x < FB_W && y < FB_H) model[y * FB_W + x] = c;
    else if (oobModel < 255) oobModel++;
  endtask

  task automatic runClear(input logic [2:0] color);
    int cycles    = 0;
    int dones     = 0;
    int badReady  = 0;
    int oobBefore = int'(oob_count);
    clr_color = color;
    clr_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    // An out-of-range write held during the clear must neither be accepted nor counted.
    wrBus.wr_valid = 1'b1;
    wrBus.wr_x     = 8'd200;
    wrBus.wr_y     = 7'd0;
    while (busy && cycles < 25000) begin
      if (wrBus.wr_ready) badReady++;
      if (clr_done) dones++;
      clr_start = (cycles == 500);
      clr_color = (cycles == 500) ? ~color : color;
      cycles++;
      @(negedge clk);
    end
    wrBus.wr_valid = 1'b0;
    clr_start      = 1'b0;
    check("clear_length", cycles, CELLS);
    check("clear_ready_low", badReady, 0);
    check("clear_done_while_busy", dones, 0);
    check("clear_done_pulse", int'(clr_done), 1);
    check("clear_oob_hold", int'(oob_count), oobBefore);
    @(negedge clk);
    check("clear_done_single", int'(clr_done), 0);
    for (int i = 0; i < CELLS; i++) model[i] = color;
  endtask

  task automatic randomRound(input int n);
    for (int k = 0; k < n; k++) begin
      doWrite($urandom_range(0, 175), $urandom_range(0, 127), 3'($urandom));
      readCheck($urandom_range(0, 1400), $urandom_range(0, 1100), "rand_read");
      if (k % 16 == 0) check("rand_oob", int'(oob_count), oobModel);
    end
  endtask

  initial begin
    int cyc;
    wrBus.wr_valid = 1'b0;
    wrBus.wr_x     = '0;
    wrBus.wr_y     = '0;
    wrBus.wr_color = '0;

    vecs[0] = '{40,   24,   3'b101};
    vecs[1] = '{47,   31,   3'b101};
    vecs[2] = '{43,   27,   3'b101};
    vecs[3] = '{48,   24,   3'b110};
    vecs[4] = '{39,   24,   3'b010};
    vecs[5] = '{1280, 24,   3'b000};
    vecs[6] = '{40,   1024, 3'b000};
    vecs[7] = '{2047, 2047, 3'b000};
    vecs[8] = '{1279, 1023, 3'b010};
    vecs[9] = '{0,    8,    3'b010};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pixel", int'(pixel_out), 0);
    check("rst_wr_ready", int'(wrBus.wr_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_clr_done", int'(clr_done), 0);
    check("rst_oob", int'(oob_count), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_release", int'(wrBus.wr_ready), 1);

    // Full clear, followed by a sweep of every cell at a random pixel inside its block
    runClear(3'b010);
    for (int i = 0; i < CELLS; i++)
      readCheck((i % FB_W) * 8 + $urandom_range(0, 7), (i / FB_W) * 8 + $urandom_range(0, 7), "sweep");

    // Out-of-range writes. wr_y is 7 bits wide, so only wr_x can leave the frame.
    doWrite(160, 0, 3'b111);
    doWrite(255, 127, 3'b111);
    check("oob_two", int'(oob_count), 2);
    readCheck(0, 8, "oob_cell160_kept");
    readCheck(1279, 1023, "oob_last_kept");
    repeat (300) doWrite($urandom_range(160, 255), $urandom_range(0, 127), 3'($urandom));
    check("oob_saturate", int'(oob_count), 255);

    // Block replication, neighbouring cells and blanking
    doWrite(5, 3, 3'b101);
    doWrite(6, 3, 3'b110);
    for (int i = 0; i < 10; i++) begin
      posX = 11'(vecs[i].px);
      posY = 11'(vecs[i].py);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), int'(pixel_out), int'(vecs[i].exp));
    end

    // A read and a write to the same cell in one cycle return the old value
    posX = 11'd44;
    posY = 11'd28;
    wrBus.wr_valid = 1'b1;
    wrBus.wr_x     = 8'd5;
    wrBus.wr_y     = 7'd3;
    wrBus.wr_color = 3'b011;
    @(posedge clk);
    @(negedge clk);
    wrBus.wr_valid = 1'b0;
    check("rw_same_old", int'(pixel_out), 5);
    model[3 * FB_W + 5] = 3'b011;
    readCheck(44, 28, "rw_same_new");

    randomRound(400);

    // A reset during a clear aborts it and leaves the fill partial
    doWrite(40, 6, 3'b111);
    clr_color = 3'b001;
    clr_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr_start = 1'b0;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_ready", int'(wrBus.wr_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    oobModel = 0;
    for (int i = 0; i < 1000; i++) model[i] = 3'b001;
    @(negedge clk);
    check("abort_ready_back", int'(wrBus.wr_ready), 1);
    check("abort_oob_zero", int'(oob_count), 0);
    check("abort_busy_idle", int'(busy), 0);
    for (int i = 0; i < 1002; i++)
      readCheck((i % FB_W) * 8, (i / FB_W) * 8, "abort_cell");

    // A write in the same cycle as clr_start is performed and then cleared over
    wrBus.wr_valid = 1'b1;
    wrBus.wr_x     = 8'd5;
    wrBus.wr_y     = 7'd0;
    wrBus.wr_color = 3'b100;
    clr_start      = 1'b1;
    clr_color      = 3'b011;
    @(posedge clk);
    @(negedge clk);
    wrBus.wr_valid = 1'b0;
    clr_start      = 1'b0;
    check("same_cycle_busy", int'(busy), 1);
    cyc = 0;
    while (busy && cyc < 25000) begin
      cyc++;
      @(negedge clk);
    end
    check("same_cycle_clear_len", cyc, CELLS);
    for (int i = 0; i < CELLS; i++) model[i] = 3'b011;
    readCheck(40, 0, "same_cycle_cell");
    readCheck(1279, 1023, "same_cycle_last");

    randomRound(200);
    check("final_oob", int'(oob_count), oobModel);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
